// File: rtl/arb_pkg.sv
// Shared types and widths for the datapath arbiters.
package arb_pkg;

  localparam int NREQ   = 8;
  localparam int SEL_W  = 3;
  localparam int BEAT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority search over eight request lines: returns the first set
// request found scanning i_ptr, i_ptr+1, ... (mod 8).
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  logic [SEL_W-1:0] w_cand;

  // Scan from the farthest slot back to i_ptr so the nearest hit is written last.
  always_comb begin
    o_idx  = '0;
    w_cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = i_ptr + SEL_W'(k);
      if (i_req[w_cand]) o_idx = w_cand;
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 8:1 32-bit select mux.
// Grants are held for at most MAX_BEATS accepted transfers, followed by one
// idle bubble before re-arbitration.
// Optional build macro ARB_PRIO0_EN: requester 0 becomes high priority.
//
// state    | meaning
// ST_IDLE  | no grant; search for the next requester from r_ptr
// ST_GRANT | r_sel owns the mux; transfers counted in r_beat
module mux8_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_BEATS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  output logic [NREQ-1:0]   o_gnt,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [BEAT_W-1:0] o_beat
);

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [BEAT_W-1:0]  r_beat, w_beat_nxt;

  logic [SEL_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic [SEL_W-1:0]   w_win;
  logic               w_granted;
  logic               w_req_sel;
  logic               w_xfer;
  logic               w_last;
  logic               w_preempt;
  logic               w_keep_ptr;
  logic               w_release;

  rr_pick8 u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_granted = (r_state == ST_GRANT);
  assign w_req_sel = i_req[r_sel];
  assign w_xfer    = w_granted && w_req_sel && i_out_ready;
  assign w_last    = (r_beat == BEAT_W'(MAX_BEATS - 1));

`ifdef ARB_PRIO0_EN
  // Requester 0 jumps the queue; a beat already accepted still completes.
  assign w_win      = i_req[0] ? '0 : w_pick_idx;
  assign w_preempt  = (r_sel != '0) && i_req[0] && (w_xfer || !w_req_sel);
  assign w_keep_ptr = (r_sel == '0);
`else
  assign w_win      = w_pick_idx;
  assign w_preempt  = 1'b0;
  assign w_keep_ptr = 1'b0;
`endif

  assign w_release = w_granted && ((w_xfer && w_last) || !w_req_sel || w_preempt);

  // State, select, pointer and beat registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Next-state and grant/valid outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_beat_nxt  = r_beat;
    o_gnt       = '0;
    o_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_win;
          w_beat_nxt  = '0;
        end
      end
      ST_GRANT: begin
        o_gnt       = NREQ'(1) << r_sel;
        o_out_valid = w_req_sel;
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_beat_nxt  = '0;
          if (!w_keep_ptr) w_ptr_nxt = r_sel + SEL_W'(1);
        end else if (w_xfer) begin
          w_beat_nxt = r_beat + BEAT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_sel  = r_sel;
  assign o_beat = r_beat;

endmodule
